multi_wave_display: RTL

Parametrised N-channel oscilloscope overlay. It replaces the practice of instantiating one single-sample display per voice and summing the colour channels outside it.
- Captures a triggered window of samples from every voice into a ping-pong buffer.
- Swaps buffers only at frame boundaries, so the displayed trace never tears.
- Renders all enabled channels per pixel with per-channel colours and saturating colour add.
- Sits between music_player (sample source) and vga_hdmi (pixel sink).

---
 rtl/multi_wave_display_if.sv | 29 ++
 rtl/multi_wave_display.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multi_wave_display_if.sv
// Sample-source and pixel-sink signal bundle for multi_wave_display.
// The master drives samples, colours and pixel coordinates; the slave returns the pixel colour.
interface multi_wave_display_if #(
   parameter int NUM_CH   = 4,
   parameter int SAMPLE_W = 16
);
   logic                       new_sample;
   logic [NUM_CH*SAMPLE_W-1:0] samples;
   logic [NUM_CH-1:0]          ch_enable;
   logic [NUM_CH*24-1:0]       ch_color;
   logic                       vsync;
   logic [10:0]                x;
   logic [9:0]                 y;
   logic                       valid;
   logic [7:0]                 r;
   logic [7:0]                 g;
   logic [7:0]                 b;
   logic                       busy;

   modport master (
      output new_sample, samples, ch_enable, ch_color, vsync, x, y, valid,
      input  r, g, b, busy
   );

   modport slave (
      input  new_sample, samples, ch_enable, ch_color, vsync, x, y, valid,
      output r, g, b, busy
   );
endinterface

// File: rtl/multi_wave_display.sv
// N-channel oscilloscope overlay: triggered capture into a ping-pong buffer, frame-synchronous
// bank swap, and a 2-cycle pixel renderer. Define WAVE_GRID_EN to overlay a grey graticule.
module multi_wave_display #(
   parameter int NUM_CH   = 4,
   parameter int SAMPLE_W = 16,
   parameter int DEPTH    = 256,
   parameter int X_SHIFT  = 2,
   parameter int CENTER_Y = 384
) (
   input logic                 clk,
   input logic                 reset,
   multi_wave_display_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = NUM_CH * SAMPLE_W;

   typedef enum logic [1:0] {ARMED, CAPTURE, DONE} state_t;

   state_t                     state;
   state_t                     state_nx;
   logic [AW-1:0]              wr_addr;
   logic [AW-1:0]              wr_ptr;
   logic [AW:0]                timeout_cnt;
   logic                       wr_bank;
   logic                       shown;
   logic                       vsync_d;
   logic                       vsync_rise;
   logic                       trigger;
   logic                       wr_en;
   logic signed [SAMPLE_W-1:0] ch0_prev;
   logic signed [SAMPLE_W-1:0] ch0_cur;

   logic [DW-1:0]              mem [2*DEPTH];
   logic [DW-1:0]              rd_data;
   logic [AW-1:0]              rd_addr;
   logic [10:0]                x_d1;
   logic [9:0]                 y_d1;
   logic                       valid_d1;
   logic                       shown_d1;
   logic [10:0]                sum_r;
   logic [10:0]                sum_g;
   logic [10:0]                sum_b;
   logic                       in_range;

   assign ch0_cur    = bus.samples[SAMPLE_W-1:0];
   assign vsync_rise = bus.vsync & ~vsync_d;
   assign trigger    = ((ch0_prev < 0) && (ch0_cur >= 0)) || (timeout_cnt == (AW+1)'(DEPTH));
   assign rd_addr    = AW'(bus.x >> X_SHIFT);

   always_ff @(posedge clk) begin
      if (reset) state <= ARMED;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ARMED:   if (bus.new_sample && trigger) state_nx = CAPTURE;
         CAPTURE: if (bus.new_sample && (wr_addr == AW'(DEPTH-1))) state_nx = DONE;
         DONE:    if (vsync_rise) state_nx = ARMED;
         default: state_nx = ARMED;
      endcase
   end

   always_comb begin
      bus.busy = (state == CAPTURE);
      wr_en    = bus.new_sample && (((state == ARMED) && trigger) || (state == CAPTURE));
      wr_ptr   = (state == ARMED) ? '0 : wr_addr;
   end

   // In DONE the swap takes priority; a coincident strobe is simply dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_addr     <= '0;
         timeout_cnt <= '0;
         wr_bank     <= 1'b0;
         shown       <= 1'b0;
         vsync_d     <= 1'b0;
         ch0_prev    <= '0;
      end else begin
         vsync_d <= bus.vsync;
         if (bus.new_sample) ch0_prev <= ch0_cur;
         case (state)
            ARMED: begin
               if (bus.new_sample) begin
                  if (trigger) begin
                     wr_addr     <= AW'(1);
                     timeout_cnt <= '0;
                  end else begin
                     timeout_cnt <= timeout_cnt + 1'b1;
                  end
               end
            end
            CAPTURE: if (bus.new_sample) wr_addr <= wr_addr + 1'b1;
            DONE: begin
               if (vsync_rise) begin
                  wr_bank     <= ~wr_bank;
                  shown       <= 1'b1;
                  timeout_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[{wr_bank, wr_ptr}] <= bus.samples;
      rd_data <= mem[{~wr_bank, rd_addr}];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_d1 <= 1'b0;
         shown_d1 <= 1'b0;
         x_d1     <= '0;
         y_d1     <= '0;
      end else begin
         valid_d1 <= bus.valid;
         shown_d1 <= shown;
         x_d1     <= bus.x;
         y_d1     <= bus.y;
      end
   end

   // Each channel's trace is three rows thick around the row of its top sample byte.
   always_comb begin
      logic signed [7:0]  top;
      logic signed [11:0] row;
      logic signed [11:0] diff;
      top   = '0;
      row   = '0;
      diff  = '0;
      sum_r = '0;
      sum_g = '0;
      sum_b = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         top  = rd_data[k*SAMPLE_W + SAMPLE_W-8 +: 8];
         row  = 12'(CENTER_Y) - {{4{top[7]}}, top};
         diff = $signed({2'b00, y_d1}) - row;
         if (shown_d1 && bus.ch_enable[k] && (diff >= -12'sd1) && (diff <= 12'sd1)) begin
            sum_r = sum_r + 11'(bus.ch_color[k*24+16 +: 8]);
            sum_g = sum_g + 11'(bus.ch_color[k*24+8 +: 8]);
            sum_b = sum_b + 11'(bus.ch_color[k*24 +: 8]);
         end
      end
`ifdef WAVE_GRID_EN
      if ((x_d1[5:0] == 6'd0) || (y_d1 == 10'(CENTER_Y))) begin
         sum_r = sum_r + 11'h40;
         sum_g = sum_g + 11'h40;
         sum_b = sum_b + 11'h40;
      end
`endif
      in_range = valid_d1 && (32'(x_d1) < (DEPTH << X_SHIFT));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.r <= '0;
         bus.g <= '0;
         bus.b <= '0;
      end else if (in_range) begin
         bus.r <= (sum_r > 11'd255) ? 8'hFF : sum_r[7:0];
         bus.g <= (sum_g > 11'd255) ? 8'hFF : sum_g[7:0];
         bus.b <= (sum_b > 11'd255) ? 8'hFF : sum_b[7:0];
      end else begin
         bus.r <= '0;
         bus.g <= '0;
         bus.b <= '0;
      end
   end
endmodule
